// File: rtl/fpu_ss_scoreboard_ctrl_if.sv
// Issue / retire bundle between the offload instruction buffer, FPnew and
// the scoreboard controller.
//   master : instruction buffer + FPnew side (drives issue/writeback info,
//            observes ready, forwarding selects and status)
//   slave  : scoreboard controller
// Signals:
//   flush_i        clear all tracking state
//   issue_valid_i  candidate instruction valid
//   issue_ready_o  instruction may issue this cycle
//   issue_rd_i     destination register
//   issue_rd_fp_i  destination is an FP register
//   issue_rs_i     source registers, operand k at [k*AW +: AW]
//   issue_rs_use_i operand k reads an FP register
//   fwd_o          operand k takes the current writeback data
//   wb_valid_i     retire event (at most one per cycle)
//   wb_fp_i        retiring result targets an FP register
//   wb_addr_i      retiring destination register
//   busy_o         inflight count is nonzero
//   inflight_o     current inflight count
//   err_o          one-cycle pulse after an illegal retire
interface fpu_ss_scoreboard_ctrl_if #(
  parameter int NUM_FPR = 32,
  parameter int NUM_SRC = 3
) ();
  localparam int AW = $clog2(NUM_FPR);

  logic                   flush_i;
  logic                   issue_valid_i;
  logic                   issue_ready_o;
  logic [AW-1:0]          issue_rd_i;
  logic                   issue_rd_fp_i;
  logic [NUM_SRC*AW-1:0]  issue_rs_i;
  logic [NUM_SRC-1:0]     issue_rs_use_i;
  logic [NUM_SRC-1:0]     fwd_o;
  logic                   wb_valid_i;
  logic                   wb_fp_i;
  logic [AW-1:0]          wb_addr_i;
  logic                   busy_o;
  logic [7:0]             inflight_o;
  logic                   err_o;

  modport master (
    output flush_i, issue_valid_i, issue_rd_i, issue_rd_fp_i, issue_rs_i,
           issue_rs_use_i, wb_valid_i, wb_fp_i, wb_addr_i,
    input  issue_ready_o, fwd_o, busy_o, inflight_o, err_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_rd_i, issue_rd_fp_i, issue_rs_i,
           issue_rs_use_i, wb_valid_i, wb_fp_i, wb_addr_i,
    output issue_ready_o, fwd_o, busy_o, inflight_o, err_o
  );
endinterface

// File: rtl/fpu_ss_scoreboard_ctrl.sv
// Issue/retire scoreboard for the FPU subsystem.
// Each FP register owns a small pending-write counter so several writes to
// the same register may be outstanding (retire order is in-order, so WAW is
// safe). Issue is gated on RAW hazards, counter saturation and a global
// in-flight limit; a same-cycle writeback to a single-pending source is
// forwarded instead of stalling.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   sb      scoreboard bundle (slave modport), see fpu_ss_scoreboard_ctrl_if
module fpu_ss_scoreboard_ctrl #(
  parameter int NUM_FPR      = 32,
  parameter int NUM_SRC      = 3,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int FORWARDING   = 1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  fpu_ss_scoreboard_ctrl_if.slave sb
);

  localparam int               AW      = $clog2(NUM_FPR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       MAX_IF  = 8'(MAX_INFLIGHT);

  // Saturating up/down step for a per-register counter. A decrement of a
  // zero counter is an illegal retire and is dropped rather than wrapping.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic dec);
    logic dec_ok;
    dec_ok = dec && (cur != '0);
    if (inc && !dec_ok) return (cur == CNT_MAX) ? cur : cur + 1'b1;
    if (dec_ok && !inc) return cur - 1'b1;
    return cur;
  endfunction

  // Same saturating step for the 8-bit in-flight counter.
  function automatic logic [7:0] if_step(input logic [7:0] cur,
                                         input logic inc,
                                         input logic dec);
    logic dec_ok;
    dec_ok = dec && (cur != 8'd0);
    if (inc && !dec_ok) return (cur == 8'hFF) ? cur : cur + 8'd1;
    if (dec_ok && !inc) return cur - 8'd1;
    return cur;
  endfunction

  logic [CNT_W-1:0]   cnt   [NUM_FPR];
  logic [CNT_W-1:0]   cnt_d [NUM_FPR];
  logic [7:0]         inflight;
  logic [7:0]         inflight_d;
  logic               err;
  logic               err_d;

  logic               wb_rel;
  logic [NUM_SRC-1:0] fwd;
  logic [NUM_SRC-1:0] dep;
  logic               rd_full;
  logic               if_full;
  logic               ready;
  logic               fire;

  assign wb_rel = sb.wb_valid_i & sb.wb_fp_i;

  // Per-operand forwarding and RAW detection. Forwarding is only safe when
  // the retiring write is the last one pending on that register.
  always_comb begin
    logic [AW-1:0] rs_k;
    fwd  = '0;
    dep  = '0;
    rs_k = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rs_k   = sb.issue_rs_i[k*AW +: AW];
      fwd[k] = (FORWARDING != 0) && sb.issue_valid_i && sb.issue_rs_use_i[k] &&
               wb_rel && (sb.wb_addr_i == rs_k) && (cnt[rs_k] == CNT_W'(1));
      dep[k] = sb.issue_rs_use_i[k] && (cnt[rs_k] != '0) && !fwd[k];
    end
  end

  // A same-cycle retire to rd frees one slot, so the full counter may still
  // take the new write and ends up unchanged.
  assign rd_full = sb.issue_rd_fp_i && (cnt[sb.issue_rd_i] == CNT_MAX) &&
                   !(wb_rel && (sb.wb_addr_i == sb.issue_rd_i));
  assign if_full = (inflight == MAX_IF) && !sb.wb_valid_i;
  assign ready   = !sb.flush_i && !(|dep) && !rd_full && !if_full;
  assign fire    = sb.issue_valid_i && ready;

  always_comb begin
    logic inc;
    logic dec;
    cnt_d = cnt;
    inc   = 1'b0;
    dec   = 1'b0;
    for (int r = 0; r < NUM_FPR; r++) begin
      inc      = fire && sb.issue_rd_fp_i && (sb.issue_rd_i == AW'(r));
      dec      = wb_rel && (sb.wb_addr_i == AW'(r));
      cnt_d[r] = sb.flush_i ? '0 : cnt_step(cnt[r], inc, dec);
    end
  end

  assign inflight_d = sb.flush_i ? 8'd0 : if_step(inflight, fire, sb.wb_valid_i);
  // A retire seen during flush is discarded silently.
  assign err_d      = !sb.flush_i &&
                      ((wb_rel && (cnt[sb.wb_addr_i] == '0)) ||
                       (sb.wb_valid_i && (inflight == 8'd0)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_FPR; r++) cnt[r] <= '0;
      inflight <= 8'd0;
      err      <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      inflight <= inflight_d;
      err      <= err_d;
    end
  end

  assign sb.issue_ready_o = ready;
  assign sb.fwd_o         = fwd;
  assign sb.busy_o        = (inflight != 8'd0);
  assign sb.inflight_o    = inflight;
  assign sb.err_o         = err;

endmodule

// File: tb/tb_fpu_ss_scoreboard_ctrl.sv
module tb_fpu_ss_scoreboard_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpu_ss_scoreboard_ctrl_if #(.NUM_FPR(32), .NUM_SRC(3)) if1 ();
  fpu_ss_scoreboard_ctrl_if #(.NUM_FPR(32), .NUM_SRC(3)) if0 ();

  // Forwarding-enabled DUT, driven directly by the bench.
  fpu_ss_scoreboard_ctrl #(.NUM_FPR(32), .NUM_SRC(3), .CNT_W(2),
                           .MAX_INFLIGHT(4), .FORWARDING(1)) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sb    (if1.slave)
  );

  // Forwarding-disabled DUT, mirrors the same stimulus.
  fpu_ss_scoreboard_ctrl #(.NUM_FPR(32), .NUM_SRC(3), .CNT_W(2),
                           .MAX_INFLIGHT(4), .FORWARDING(0)) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sb    (if0.slave)
  );

  assign if0.flush_i        = if1.flush_i;
  assign if0.issue_valid_i  = if1.issue_valid_i;
  assign if0.issue_rd_i     = if1.issue_rd_i;
  assign if0.issue_rd_fp_i  = if1.issue_rd_fp_i;
  assign if0.issue_rs_i     = if1.issue_rs_i;
  assign if0.issue_rs_use_i = if1.issue_rs_use_i;
  assign if0.wb_valid_i     = if1.wb_valid_i;
  assign if0.wb_fp_i        = if1.wb_fp_i;
  assign if0.wb_addr_i      = if1.wb_addr_i;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [4:0]  rd;
    logic        rd_fp;
    logic [14:0] rs;
    logic [2:0]  rs_use;
    logic        wbv;
    logic        wbfp;
    logic [4:0]  wba;
    logic        ready;   // expected before the edge
    logic [2:0]  fwd;     // expected before the edge
    logic [7:0]  infl;    // expected after the edge
    logic        busy;    // expected after the edge
    logic        err;     // expected after the edge
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic fl, input logic v, input logic [4:0] rd,
                              input logic rdfp, input logic [14:0] rs,
                              input logic [2:0] ru, input logic wbv,
                              input logic wbfp, input logic [4:0] wba,
                              input logic rdy, input logic [2:0] fw,
                              input logic [7:0] infl, input logic busy,
                              input logic err);
    vec_t t;
    t.flush = fl; t.valid = v; t.rd = rd; t.rd_fp = rdfp; t.rs = rs;
    t.rs_use = ru; t.wbv = wbv; t.wbfp = wbfp; t.wba = wba;
    t.ready = rdy; t.fwd = fw; t.infl = infl; t.busy = busy; t.err = err;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if1.flush_i        = v.flush;
    if1.issue_valid_i  = v.valid;
    if1.issue_rd_i     = v.rd;
    if1.issue_rd_fp_i  = v.rd_fp;
    if1.issue_rs_i     = v.rs;
    if1.issue_rs_use_i = v.rs_use;
    if1.wb_valid_i     = v.wbv;
    if1.wb_fp_i        = v.wbfp;
    if1.wb_addr_i      = v.wba;
  endtask

  task automatic cyc_begin(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #2;
    chk({nm, ".ready"}, 32'(if1.issue_ready_o), 32'(v.ready));
    chk({nm, ".fwd"},   32'(if1.fwd_o),         32'(v.fwd));
  endtask

  task automatic cyc_end(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    chk({nm, ".inflight"}, 32'(if1.inflight_o), 32'(v.infl));
    chk({nm, ".busy"},     32'(if1.busy_o),     32'(v.busy));
    chk({nm, ".err"},      32'(if1.err_o),      32'(v.err));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    cyc_begin(v, nm);
    cyc_end(v, nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t idle;
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle   = mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0);
    drive(idle);

    //        fl v  rd rdfp rs   use   wbv wbfp wba  rdy fwd   infl busy err
    tbl[0]  = mk(0,1, 7,1, 15'd0,  3'b000, 0,0,0,  1,3'b000, 4,1,0);
    tbl[0].infl = 8'd1;
    tbl[1]  = mk(0,1, 7,1, 15'd0,  3'b000, 0,0,0,  1,3'b000, 2,1,0);
    tbl[2]  = mk(0,1, 7,1, 15'd0,  3'b000, 0,0,0,  1,3'b000, 3,1,0);
    tbl[3]  = mk(0,1, 7,1, 15'd0,  3'b000, 0,0,0,  0,3'b000, 3,1,0);
    tbl[4]  = mk(0,1, 7,1, 15'd0,  3'b000, 1,1,7,  1,3'b000, 3,1,0);
    tbl[5]  = mk(0,1, 7,1, 15'd0,  3'b000, 0,0,0,  0,3'b000, 3,1,0);
    tbl[6]  = mk(0,1, 1,1, 15'd0,  3'b000, 0,0,0,  1,3'b000, 4,1,0);
    tbl[7]  = mk(0,1, 2,1, 15'd0,  3'b000, 0,0,0,  0,3'b000, 4,1,0);
    tbl[8]  = mk(0,1, 2,1, 15'd0,  3'b000, 1,1,7,  1,3'b000, 4,1,0);
    tbl[9]  = mk(0,0, 0,0, 15'd0,  3'b000, 1,1,7,  1,3'b000, 3,1,0);
    tbl[10] = mk(0,1, 0,0, 15'd7,  3'b001, 1,1,1,  0,3'b000, 2,1,0);
    tbl[11] = mk(0,1, 0,0, 15'd7,  3'b001, 1,1,7,  1,3'b001, 2,1,0);
    tbl[12] = mk(0,0, 0,0, 15'd0,  3'b000, 1,1,2,  1,3'b000, 1,1,0);
    tbl[13] = mk(0,0, 0,0, 15'd0,  3'b000, 1,0,0,  1,3'b000, 0,0,0);
    tbl[14] = mk(0,0, 0,0, 15'd0,  3'b000, 1,1,9,  1,3'b000, 0,0,1);
    tbl[15] = mk(0,0, 0,0, 15'd0,  3'b000, 0,0,0,  1,3'b000, 0,0,0);
    tbl[16] = mk(0,1, 0,0, 15'd288,3'b010, 0,0,0,  1,3'b000, 1,1,0);
    tbl[17] = mk(0,0, 0,0, 15'd0,  3'b000, 1,0,0,  1,3'b000, 0,0,0);
    tbl[18] = mk(0,0, 0,0, 15'd0,  3'b000, 1,0,0,  1,3'b000, 0,0,1);
    tbl[19] = mk(0,0, 0,0, 15'd0,  3'b000, 0,0,0,  1,3'b000, 0,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("reset.ready",    32'(if1.issue_ready_o), 32'd1);
    chk("reset.fwd",      32'(if1.fwd_o),         32'd0);
    chk("reset.busy",     32'(if1.busy_o),        32'd0);
    chk("reset.inflight", 32'(if1.inflight_o),    32'd0);
    chk("reset.err",      32'(if1.err_o),         32'd0);

    // WAW saturation, in-flight limit, forwarding, illegal retires
    for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-stream with cnt[3]=2, inflight=2
    do_reset();
    run_vec(mk(0,1,3,1,15'd0,3'b000,0,0,0, 1,3'b000,1,1,0), "rst_pre0");
    run_vec(mk(0,1,3,1,15'd0,3'b000,0,0,0, 1,3'b000,2,1,0), "rst_pre1");
    @(negedge clk);
    drive(mk(0,1,0,0,15'd3,3'b001,0,0,0, 1,3'b000,0,0,0));
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ready",    32'(if1.issue_ready_o), 32'd1);
    chk("rst_mid.inflight", 32'(if1.inflight_o),    32'd0);
    chk("rst_mid.busy",     32'(if1.busy_o),        32'd0);
    chk("rst_mid.err",      32'(if1.err_o),         32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold.inflight", 32'(if1.inflight_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_rel.ready", 32'(if1.issue_ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_rel.inflight", 32'(if1.inflight_o), 32'd1);

    // RAW with a 3-cycle FPU latency, forwarding on (dut1) and off (dut0)
    do_reset();
    run_vec(mk(0,1,5,1,15'd0,3'b000,0,0,0, 1,3'b000,1,1,0), "raw_c0");
    for (int c = 1; c <= 2; c++) begin
      v = mk(0,1,0,0,15'd5,3'b001,0,0,0, 0,3'b000,1,1,0);
      cyc_begin(v, $sformatf("raw_c%0d", c));
      chk($sformatf("raw_c%0d.ready_nofwd", c), 32'(if0.issue_ready_o), 32'd0);
      cyc_end(v, $sformatf("raw_c%0d", c));
    end
    v = mk(0,1,0,0,15'd5,3'b001,1,1,5, 1,3'b001,1,1,0);
    cyc_begin(v, "raw_c3");
    chk("raw_c3.ready_nofwd", 32'(if0.issue_ready_o), 32'd0);
    chk("raw_c3.fwd_nofwd",   32'(if0.fwd_o),         32'd0);
    cyc_end(v, "raw_c3");
    chk("raw_c3.inflight_nofwd", 32'(if0.inflight_o), 32'd0);
    v = mk(0,1,0,0,15'd5,3'b001,0,0,0, 1,3'b000,2,1,0);
    cyc_begin(v, "raw_c4");
    chk("raw_c4.ready_nofwd", 32'(if0.issue_ready_o), 32'd1);
    chk("raw_c4.fwd_nofwd",   32'(if0.fwd_o),         32'd0);
    cyc_end(v, "raw_c4");
    chk("raw_c4.inflight_nofwd", 32'(if0.inflight_o), 32'd1);

    // Flush with cnt[2]=1, inflight=3, issue and retire in the flush cycle
    do_reset();
    run_vec(mk(0,1, 2,1,15'd0,3'b000,0,0,0, 1,3'b000,1,1,0), "fl_pre0");
    run_vec(mk(0,1,10,1,15'd0,3'b000,0,0,0, 1,3'b000,2,1,0), "fl_pre1");
    run_vec(mk(0,1,11,1,15'd0,3'b000,0,0,0, 1,3'b000,3,1,0), "fl_pre2");
    run_vec(mk(1,1,12,1,15'd0,3'b000,1,1,10, 0,3'b000,0,0,0), "flush");
    run_vec(mk(0,1, 0,0,15'd2,3'b001,0,0,0, 1,3'b000,1,1,0), "fl_post");

    @(negedge clk);
    drive(idle);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
